// File: rtl/sp_ram_burst_writer.sv
// 16x4 RAM filled in wrapping bursts from a valid/ready stream; writes land on the handshake edge, reads return 1 cycle after rd_en.
// Backpressure: in_ready is high only in WRITE; a low in_valid stalls the burst, and reads are dropped outside IDLE.
module sp_ram_burst_writer #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] remain;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              start_fire;
    logic              wr_fire;
    logic              rd_fire;

    assign start_fire = (state == IDLE) && start;
    // abort wins over a simultaneous handshake: the word is not stored
    assign wr_fire    = (state == WRITE) && in_valid && !abort;
    assign rd_fire    = (state == IDLE) && rd_en;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (in_valid && (remain == '0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            remain   <= '0;
            wr_count <= '0;
        end else begin
            state <= state_nxt;
            if (start_fire) begin
                wr_ptr   <= base_addr;
                remain   <= len;
                wr_count <= '0;
            end else if (wr_fire) begin
                wr_ptr   <= wr_ptr + PTR_ONE;
                wr_count <= wr_count + CNT_ONE;
                if (remain != '0) begin
                    remain <= remain - PTR_ONE;
                end
            end
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_burst_writer.sv
// Directed bench for sp_ram_burst_writer: bursts, wrap, stalls, abort, ignored requests, async reset.
module tb_sp_ram_burst_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [3:0] len;
    logic       abort;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [4:0] wr_count;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic       rd_valid;

    int checks   = 0;
    int failures = 0;

    sp_ram_burst_writer #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .wr_count(wr_count), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [3:0] b, input logic [3:0] l);
        start = 1'b1; base_addr = b; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [3:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, rd_valid, 1);
        chk(tag, rd_data, exp);
    endtask

    logic [3:0] bp_dat [6];
    logic       bp_vld [6];

    initial begin
        int ready_cycles;
        int hs;
        rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_addr = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_count", wr_count, 0);
        tick(); tick();
        #3 rst = 1'b1;
        tick();

        // full burst, base 0, len 15
        start_burst(4'd0, 4'd15);
        chk("full_wr_count_clr", wr_count, 0);
        ready_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (in_ready === 1'b1) ready_cycles++;
            write_word(4'(15 - i));
        end
        chk("full_ready_cycles", ready_cycles, 16);
        chk("full_done", done, 1);
        chk("full_busy_in_done", busy, 0);
        chk("full_in_ready_in_done", in_ready, 0);
        chk("full_wr_count", wr_count, 16);
        tick();
        chk("full_done_pulse", done, 0);
        for (int i = 0; i < 16; i++) read_chk("full_rd", 4'(i), 4'(15 - i));
        tick();
        chk("rd_valid_drop", rd_valid, 0);
        chk("rd_data_hold", rd_data, 0);

        // wrap-around, base 14, len 3
        start_burst(4'd14, 4'd3);
        write_word(4'hA); write_word(4'hB); write_word(4'hC); write_word(4'hD);
        chk("wrap_done", done, 1);
        tick();
        read_chk("wrap_14", 4'd14, 4'hA);
        read_chk("wrap_15", 4'd15, 4'hB);
        read_chk("wrap_0", 4'd0, 4'hC);
        read_chk("wrap_1", 4'd1, 4'hD);
        read_chk("wrap_2_kept", 4'd2, 4'd13);

        // backpressure, base 5, len 2, valid 1,0,0,1,0,1
        bp_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bp_dat = '{4'd1, 4'd9, 4'd9, 4'd2, 4'd9, 4'd3};
        start_burst(4'd5, 4'd2);
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = bp_vld[i]; in_data = bp_dat[i];
            tick();
            in_valid = 1'b0;
            if (bp_vld[i]) hs++;
            chk("bp_busy", busy, (hs < 3) ? 1 : 0);
            chk("bp_done", done, (hs == 3) ? 1 : 0);
            chk("bp_wr_count", wr_count, hs);
        end
        tick();
        read_chk("bp_5", 4'd5, 4'd1);
        read_chk("bp_6", 4'd6, 4'd2);
        read_chk("bp_7", 4'd7, 4'd3);
        read_chk("bp_8_kept", 4'd8, 4'd7);

        // abort with a simultaneous valid word
        start_burst(4'd0, 4'd7);
        write_word(4'd1); write_word(4'd2); write_word(4'd3);
        abort = 1'b1; in_valid = 1'b1; in_data = 4'd9;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_wr_count", wr_count, 3);
        tick();
        chk("abort_done_later", done, 0);
        read_chk("abort_3_kept", 4'd3, 4'd12);
        read_chk("abort_2", 4'd2, 4'd3);

        // ignored start/read during WRITE, ignored start in DONE
        start_burst(4'd2, 4'd1);
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        rd_en = 1'b0;
        chk("ign_rd_valid", rd_valid, 0);
        chk("ign_rd_hold", rd_data, 3);
        write_word(4'd6);
        chk("ign_busy", busy, 1);
        start = 1'b1; base_addr = 4'd9; len = 4'd15; in_valid = 1'b1; in_data = 4'd7;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("ign_start_write_done", done, 1);
        start = 1'b1; base_addr = 4'd12; len = 4'd0; rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        start = 1'b0; rd_en = 1'b0;
        chk("ign_start_done_busy", busy, 0);
        chk("ign_rd_in_done", rd_valid, 0);
        tick();
        chk("ign_start_done_busy2", busy, 0);
        read_chk("ign_2", 4'd2, 4'd6);
        read_chk("ign_3", 4'd3, 4'd7);
        read_chk("ign_9_kept", 4'd9, 4'd6);

        // start and read together in IDLE
        start = 1'b1; base_addr = 4'd2; len = 4'd0; rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        start = 1'b0; rd_en = 1'b0;
        chk("sim_rd_valid", rd_valid, 1);
        chk("sim_rd_old", rd_data, 6);
        chk("sim_busy", busy, 1);
        write_word(4'd8);
        chk("sim_done", done, 1);
        tick();
        read_chk("sim_2_new", 4'd2, 4'd8);

        // asynchronous reset in the middle of a burst
        start_burst(4'd10, 4'd5);
        write_word(4'd1); write_word(4'd2);
        chk("arst_pre_count", wr_count, 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_done", done, 0);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_wr_count", wr_count, 0);
        chk("arst_rd_data", rd_data, 0);
        tick(); tick();
        #2 rst = 1'b1;
        tick();
        read_chk("arst_10", 4'd10, 4'd1);
        read_chk("arst_11", 4'd11, 4'd2);
        read_chk("arst_0", 4'd0, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_ram_burst_writer.md
Name: sp_ram_burst_writer

Overview:
- Write-side companion to the team's 16x4 single-port ROM.
- Owns a 16-entry x 4-bit memory array and fills it from a valid/ready data stream in bursts.
- A burst starts at a programmable base address, runs for a programmable length, and wraps modulo depth.
- A registered read port, with the same one-cycle latency as the ROM, lets downstream logic read contents back when no burst is active.

Parameters:
- DATA_W, 4, memory word width.
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  burst request; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address, latched on accepted start.
- len  in  ADDR_W  burst length minus one (0 = 1 word, 15 = 16 words), latched on accepted start.
- abort  in  1  terminates an active burst.
- in_valid  in  1  write data valid.
- in_data  in  DATA_W  write data.
- in_ready  out  1  block accepts in_data this cycle.
- busy  out  1  high in WRITE state.
- done  out  1  one-cycle pulse when a burst completes normally.
- wr_count  out  ADDR_W+1  words written in current/last burst (0..16).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  high the cycle rd_data carries a fresh read.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - in_ready, busy, done, rd_valid = 0; rd_data = 0; wr_count = 0.
  - Internal pointer and remaining counter = 0.
  - Memory array is not cleared; its contents are undefined until written.
- FSM states are IDLE, WRITE, DONE.
- IDLE:
  - in_ready = 0.
  - start=1 → latch base_addr into wr_ptr and len into remain, clear wr_count, go to WRITE next cycle.
  - abort is ignored in IDLE.
- WRITE:
  - busy = 1, in_ready = 1 (combinational from state).
  - Handshake is in_valid & in_ready. On handshake:
    - mem[wr_ptr] <= in_data
    - wr_ptr <= wr_ptr+1 mod 16
    - wr_count <= wr_count+1
    - if remain==0, go to DONE; else remain <= remain-1.
  - in_valid=0 stalls the burst indefinitely with no state change.
  - abort=1 → go to IDLE next cycle. No write occurs that cycle even if in_valid=1, done is not pulsed, words already written are retained, and wr_count holds its value.
  - start is ignored while in WRITE.
- DONE: lasts exactly one cycle, with done = 1, in_ready = 0, busy = 0; then go to IDLE. A start in this cycle is ignored.
- Wrap-around: an address past 15 wraps to 0. With len=15 every location is written exactly once regardless of base.
- Read port:
  - When rd_en=1 and state==IDLE: rd_data <= mem[rd_addr] and rd_valid <= 1 on the same edge, so data appears 1 cycle after the request.
  - When rd_en=1 in WRITE or DONE: the read is dropped, rd_valid <= 0, and rd_data holds.
  - When rd_en=0: rd_valid <= 0 and rd_data holds its last value (never X).
- Simultaneous start and rd_en in IDLE: both are honoured. The read returns pre-burst contents.
- Reset mid-burst: an immediate return to IDLE. Locations already written keep their data; a partially latched word is not guaranteed.

Test Plan:
- Full burst: rst pulse low, then start with base=0, len=15, stream in_data=15-i for i=0..15 back-to-back → in_ready high for 16 cycles, done pulses once on cycle 17, wr_count=16. Reading addr 0..15 then returns 15,14,...,0, each valid 1 cycle after rd_en.
- Wrap-around: start with base=14, len=3, data A,B,C,D → mem[14]=A, mem[15]=B, mem[0]=C, mem[1]=D; mem[2] unchanged from its prior value.
- Backpressure: base=5, len=2, in_valid toggled 1,0,0,1,0,1 → exactly 3 writes at addresses 5,6,7; done asserts only after the third handshake; busy stays high throughout the gaps.
- Abort: base=0, len=7, write 3 words, then assert abort together with in_valid=1 and data=9 → no write at addr 3, no done pulse, wr_count=3, state returns to IDLE. A later read of addr 3 shows its old value.
- Ignored requests: start during WRITE does not change base or len; rd_en during WRITE gives rd_valid=0 and rd_data unchanged; start in the DONE cycle is ignored.
- Async reset mid-burst: drive rst low between clock edges during WRITE → busy, in_ready, done, rd_valid and wr_count go to 0 immediately. After release, previously written words read back intact.
